// File: rtl/ahb_apb_bridge.sv
// Single-slave AHB-to-APB bridge: one word transfer at a time, AHB stalled
// with HREADY low until the APB slave completes, two-cycle ERROR response.
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic [1:0]            HRESP,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [2:0] state;
  logic       accept;
  logic       illegal;

  // NONSEQ and SEQ both start a transfer; IDLE and BUSY do not.
  assign accept  = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign illegal = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      HREADY  <= 1'b1;
      HRESP   <= RESP_OKAY;
      HRDATA  <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
            HREADY <= 1'b0;
            if (illegal) begin
              HRESP <= RESP_ERROR;
              state <= S_ERR1;
            end else if (HWRITE) begin
              HRESP <= RESP_OKAY;
              state <= S_WDATA;
            end else begin
              HRESP <= RESP_OKAY;
              PSEL  <= 1'b1;
              state <= S_SETUP;
            end
          end else begin
            HREADY <= 1'b1;
            HRESP  <= RESP_OKAY;
          end
        end
        // Write data arrives one cycle after the address phase.
        S_WDATA: begin
          PWDATA <= HWDATA;
          PSEL   <= 1'b1;
          state  <= S_SETUP;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (!PWRITE) begin
              HRDATA <= PRDATA;
            end
            if (PSLVERR) begin
              HRESP <= RESP_ERROR;
              state <= S_ERR1;
            end else begin
              HREADY <= 1'b1;
              HRESP  <= RESP_OKAY;
              state  <= S_IDLE;
            end
          end
        end
        S_ERR1: begin
          HREADY <= 1'b1;
          state  <= S_ERR2;
        end
        S_ERR2: begin
          HRESP <= RESP_OKAY;
          state <= S_IDLE;
        end
        default: begin
          HREADY  <= 1'b1;
          HRESP   <= RESP_OKAY;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomized bench for ahb_apb_bridge: AHB driver, APB slave model and an
// AHB completion monitor, all checked against queued expectations.
module tb_ahb_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        resp;
    int          low;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } apb_t;

  exp_t        exp_q[$];
  apb_t        apb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hready"}, HREADY, 1);
    check({tag, "_hresp"}, HRESP, 0);
    check({tag, "_hrdata"}, HRDATA, 0);
    check({tag, "_psel"}, PSEL, 0);
    check({tag, "_penable"}, PENABLE, 0);
    check({tag, "_paddr"}, PADDR, 0);
    check({tag, "_pwrite"}, PWRITE, 0);
    check({tag, "_pwdata"}, PWDATA, 0);
  endtask

  // AHB completion monitor: counts HREADY-low cycles and checks each response.
  int   mon_low = 0;
  logic mon_post_err = 1'b0;
  exp_t mon_e;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      mon_low      = 0;
      mon_post_err = 1'b0;
      last_rdata   = '0;
    end else begin
      if (mon_post_err) begin
        check("okay_after_error", {HREADY, HRESP}, 3'b100);
        mon_post_err = 1'b0;
      end
      if (!HREADY) begin
        mon_low++;
      end else if (mon_low > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("hresp", HRESP, mon_e.resp ? 2'b01 : 2'b00);
          check("hready_low_cycles", mon_low, mon_e.low);
          if (mon_e.rd) last_rdata = mon_e.rdata;
          check("hrdata", HRDATA, last_rdata);
          $display("txn done: resp=%0d hready_low=%0d hrdata=%08h", HRESP, mon_low, HRDATA);
          mon_post_err = mon_e.resp;
        end
        mon_low = 0;
      end
    end
  end

  // APB slave model: pops the expected access at SETUP, inserts wait states.
  apb_t cur;
  logic have_cur = 1'b0;
  int   acc_cnt = 0;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      have_cur = 1'b0;
      acc_cnt  = 0;
      PREADY   = 1'b0;
    end else begin
      if (PENABLE && !PSEL) check("penable_without_psel", 1, 0);
      if (!PSEL) begin
        have_cur = 1'b0;
        acc_cnt  = 0;
        PREADY   = 1'($urandom_range(0, 1));
        PRDATA   = $urandom;
        PSLVERR  = 1'($urandom_range(0, 1));
      end else if (!PENABLE) begin
        if (have_cur) begin
          check("setup_one_cycle", 1, 0);
        end else if (apb_q.size() == 0) begin
          check("unexpected_psel", 1, 0);
        end else begin
          cur = apb_q.pop_front();
          have_cur = 1'b1;
          check("setup_paddr", PADDR, cur.addr);
          check("setup_pwrite", PWRITE, cur.wr);
          if (cur.wr) check("setup_pwdata", PWDATA, cur.wdata);
          PRDATA  = cur.rdata;
          PSLVERR = cur.err;
          PREADY  = 1'($urandom_range(0, 1));
        end
      end else begin
        if (!have_cur) begin
          check("access_without_setup", 1, 0);
        end else begin
          check("access_paddr", PADDR, cur.addr);
          check("access_pwrite", PWRITE, cur.wr);
          if (cur.wr) check("access_pwdata", PWDATA, cur.wdata);
          acc_cnt++;
          PREADY = (acc_cnt > cur.waits);
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge HCLK);
    while (!(HREADY === 1'b1 && HRESP === 2'b00) && t < 200) begin
      @(negedge HCLK);
      t++;
    end
    if (t >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] rdata, input logic err);
    exp_t e;
    apb_t a;
    logic legal;
    int   t;
    wait_idle();
    legal   = (size == 3'b010) && (addr[1:0] == 2'b00);
    e.resp  = !legal || err;
    e.low   = legal ? ((wr ? 3 : 2) + waits + (err ? 1 : 0)) : 1;
    e.rd    = legal && !wr;
    e.rdata = rdata;
    exp_q.push_back(e);
    if (legal) begin
      a.addr = addr; a.wr = wr; a.wdata = wdata;
      a.waits = waits; a.rdata = rdata; a.err = err;
      apb_q.push_back(a);
    end
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = 2'($urandom_range(2, 3));
    @(posedge HCLK);
    #1;
    HTRANS = 2'($urandom_range(0, 1));
    HWDATA = wdata;
    HADDR  = $urandom;
    HWRITE = 1'($urandom_range(0, 1));
    HSIZE  = 3'($urandom_range(0, 7));
    @(posedge HCLK);
    #1;
    HWDATA = $urandom;
    t = 0;
    @(negedge HCLK);
    while (HREADY !== 1'b1 && t < 200) begin
      @(negedge HCLK);
      t++;
    end
    if (t >= 200) check("completion_timeout", 1, 0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    int          t;
    apb_t        a;

    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset("reset");
    #2 HRESETn = 1'b1;

    do_txn(32'h4000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    do_txn(32'h4000_0020, 1'b0, 3'b010, 32'h0, 0, 32'h1234_5678, 1'b0);
    do_txn(32'h4000_0030, 1'b0, 3'b010, 32'h0, 3, 32'hCAFE_F00D, 1'b0);
    do_txn(32'h4000_0040, 1'b1, 3'b010, 32'h0BAD_0BAD, 1, 32'h0, 1'b1);
    do_txn(32'h4000_0050, 1'b1, 3'b000, 32'h1111_2222, 0, 32'h0, 1'b0);
    do_txn(32'h4000_0002, 1'b0, 3'b010, 32'h0, 0, 32'h5555_AAAA, 1'b0);
    do_txn(32'h4000_0060, 1'b0, 3'b010, 32'h0, 2, 32'h7777_8888, 1'b1);

    // Reset pulsed during a long ACCESS phase.
    wait_idle();
    a.addr = 32'h4000_0008; a.wr = 1'b0; a.wdata = '0;
    a.waits = 50; a.rdata = 32'h9999_9999; a.err = 1'b0;
    apb_q.push_back(a);
    HADDR = a.addr; HWRITE = 1'b0; HSIZE = 3'b010; HTRANS = 2'b10;
    @(posedge HCLK);
    #1 HTRANS = 2'b00;
    t = 0;
    @(negedge HCLK);
    while (!(PSEL === 1'b1 && PENABLE === 1'b1) && t < 50) begin
      @(negedge HCLK);
      t++;
    end
    check("reach_access_before_reset", {PSEL, PENABLE}, 2'b11);
    @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1 check_reset("async_reset");
    apb_q.delete();
    exp_q.delete();
    @(negedge HCLK);
    #2 HRESETn = 1'b1;

    do_txn(32'h4000_0004, 1'b0, 3'b010, 32'h0, 0, 32'hA5A5_5A5A, 1'b0);

    for (int i = 0; i < 40; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      size = 3'b010;
      if ($urandom_range(0, 7) == 0) size = 3'($urandom_range(0, 7));
      do_txn(addr, 1'($urandom_range(0, 1)), size, $urandom, $urandom_range(0, 3),
             $urandom, ($urandom_range(0, 5) == 0));
    end

    wait_idle();
    repeat (2) @(negedge HCLK);
    check("queues_drained", exp_q.size() + apb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Single-slave AHB-to-APB bridge sitting directly downstream of the AHB master. It accepts one word-sized AHB transfer at a time, converts it into an APB SETUP/ACCESS sequence, stalls the AHB side with HREADY low until the APB slave completes, and returns read data and OKAY/ERROR responses. It is the only AHB slave on its bus, so it has no HSEL input. Its HREADY output drives the master's HREADY input.

## Interface
- ADDR_WIDTH, 32, width of HADDR and PADDR
- DATA_WIDTH, 32, width of all data buses
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HADDR  in  ADDR_WIDTH  AHB address (address phase)
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write, 0 = read
- HSIZE  in  3  transfer size; only 010 (word) is legal
- HWDATA  in  DATA_WIDTH  write data (data phase, the cycle after the address phase)
- HRDATA  out  DATA_WIDTH  read data, registered
- HREADY  out  1  transfer done / bridge free
- HRESP  out  2  00 OKAY, 01 ERROR
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable (ACCESS phase)
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB slave ready
- PSLVERR  in  1  APB slave error, valid with PREADY

## Operation
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- A transfer is accepted at a rising edge only when the state is IDLE and HTRANS[1] = 1 (NONSEQ or SEQ; SEQ is treated as NONSEQ).
  - HTRANS IDLE or BUSY in IDLE is ignored, and the bridge keeps HREADY=1, HRESP=00.
  - HTRANS in every other state is ignored.
- On acceptance, the bridge latches HADDR into PADDR and HWRITE into PWRITE, and drives HREADY to 0.
  - If HSIZE ≠ 010 or HADDR[1:0] ≠ 00, go to ERR1 with no APB access (PSEL stays 0).
  - Otherwise, a write goes to WDATA and a read goes to SETUP with PSEL=1.
- WDATA: at the next edge, latch HWDATA into PWDATA, set PSEL=1, and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. At the next edge, set PENABLE=1 and go to ACCESS.
- ACCESS: hold PADDR, PWRITE, PWDATA, PSEL=1 and PENABLE=1 while PREADY=0 (unbounded wait). When PREADY=1 is sampled:
  - Set PSEL=0 and PENABLE=0.
  - On a read, latch PRDATA into HRDATA.
  - If PSLVERR=1, go to ERR1.
  - Otherwise set HREADY=1, HRESP=00, and go to IDLE.
- ERR1: HREADY=0, HRESP=01. At the next edge, go to ERR2.
- ERR2: HREADY=1, HRESP=01. At the next edge, set HRESP=00 and go to IDLE.
- HRDATA holds its last value across writes and errors. On a read with PSLVERR, HRDATA still takes PRDATA.
- PADDR, PWRITE and PWDATA hold their last values when PSEL=0.

## Timing
- Reset values (asynchronous, applied immediately, including mid-transfer):
  - HREADY=1, HRESP=00, HRDATA=0
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0
  - state=IDLE
- An APB transfer interrupted by reset is abandoned with no completion.
- Read with zero APB wait states, accepted at edge E0:
  - SETUP during E0–E1, ACCESS during E1–E2, PREADY sampled at E2.
  - HREADY=1 with valid HRDATA from E2, so the master completes at E3.
  - HREADY is low for 2 cycles.
- Write: one extra cycle for WDATA. PSEL rises at E1, and HREADY is low for 3 cycles.
- Each APB wait state (PREADY=0 in ACCESS) adds exactly one cycle.
- ERROR response is always the two-cycle form: exactly 1 cycle of HREADY=0 with HRESP=01, then 1 cycle of HREADY=1 with HRESP=01.
- PENABLE is never 1 unless PSEL=1. PSEL is never 1 for more than one transfer without passing through IDLE.

## Test plan
- Write 0x4000_0010 ← 0xDEAD_BEEF, PREADY tied to 1:
  - One SETUP cycle with PADDR=0x4000_0010, PWRITE=1, PWDATA=0xDEAD_BEEF, then one ACCESS cycle.
  - HREADY low for 3 cycles, HRESP=00.
- Read 0x4000_0020 with PRDATA=0x1234_5678, no wait states: HRDATA=0x1234_5678 when HREADY returns to 1, HREADY low for 2 cycles, HRESP=00.
- Read with PREADY held low for 3 ACCESS cycles: ACCESS lasts 4 cycles, HREADY low for 5 cycles, and address and controls stay stable throughout.
- Write with PSLVERR=1 at completion: HRESP=01 in exactly 2 cycles (HREADY 0 then 1), then HRESP=00 and HREADY=1 in IDLE.
- Byte transfer (HSIZE=000) or address 0x4000_0002: PSEL never asserts, and the two-cycle ERROR is returned starting the cycle after acceptance.
- HRESETn pulsed low during ACCESS: all outputs take their reset values immediately. A following read of 0x4000_0004 completes normally.
